// File: rtl/st_pkt_arbiter.sv
// st_pkt_arbiter: round-robin packet arbiter merging N_SRC Avalon-ST turbo decoder streams into one
module st_pkt_arbiter #(
    parameter int N_SRC     = 4,
    parameter int ST        = 8,
    parameter int PKT_BEATS = 128,
    parameter int GW        = $clog2(N_SRC)
) (
    input  logic                clk_st,
    input  logic                rst_n,
    input  logic                cfg_en,
    input  logic [N_SRC*ST-1:0] src_data,
    input  logic [N_SRC-1:0]    src_valid,
    input  logic [N_SRC-1:0]    src_sop,
    input  logic [N_SRC-1:0]    src_eop,
    output logic [N_SRC-1:0]    src_ready,
    output logic [ST-1:0]       dst_data,
    output logic                dst_valid,
    output logic                dst_sop,
    output logic                dst_eop,
    input  logic                dst_ready,
    output logic [GW-1:0]       grant_id,
    output logic                busy,
    output logic                len_err,
    output logic [15:0]         pkt_cnt
);
    localparam int BW = $clog2(PKT_BEATS);
    localparam logic [BW-1:0] LAST_BEAT = BW'(PKT_BEATS - 1);

    typedef enum logic {IDLE, XFER} state_t;

    state_t         r_state, w_next;
    logic [GW-1:0]  r_grant, r_last, w_pick, w_idx;
    logic [BW-1:0]  r_cnt;
    logic [15:0]    r_pkt_cnt;
    logic           r_len_err;
    logic [N_SRC-1:0] w_req;
    logic           w_found, w_start, w_xfer, w_done, w_src_eop;

    assign w_req     = src_valid & src_sop;
    assign w_start   = (r_state == IDLE) & cfg_en & w_found;
    assign w_xfer    = dst_valid & dst_ready;
    assign w_done    = w_xfer & dst_eop;
    assign w_src_eop = src_eop[r_grant];
    assign grant_id  = r_grant;
    assign busy      = (r_state == XFER);
    assign len_err   = r_len_err;
    assign pkt_cnt   = r_pkt_cnt;

    // Round-robin search: first SOP requester after the last granted source
    always_comb begin
        w_pick  = '0;
        w_found = 1'b0;
        w_idx   = r_last;
        for (int k = 0; k < N_SRC; k++) begin
            w_idx = (w_idx == GW'(N_SRC - 1)) ? '0 : w_idx + 1'b1;
            if (!w_found && w_req[w_idx]) begin
                w_pick  = w_idx;
                w_found = 1'b1;
            end
        end
    end

    // Next state and stream steering; IDLE drains orphan non-SOP beats
    always_comb begin
        w_next    = r_state;
        src_ready = src_valid & ~src_sop;
        dst_data  = '0;
        dst_valid = 1'b0;
        dst_sop   = 1'b0;
        dst_eop   = 1'b0;
        if (r_state == IDLE) begin
            if (w_start) w_next = XFER;
        end else begin
            src_ready          = '0;
            src_ready[r_grant] = dst_ready;
            dst_data           = src_data[r_grant*ST +: ST];
            dst_valid          = src_valid[r_grant];
            dst_sop            = src_sop[r_grant] & (r_cnt == '0);
            dst_eop            = src_eop[r_grant] | (r_cnt == LAST_BEAT);
            if (dst_valid && dst_ready && dst_eop) w_next = IDLE;
        end
    end

    // State register
    always_ff @(posedge clk_st) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Grant capture, beat counting, packet counting and length-violation pulse
    always_ff @(posedge clk_st) begin
        if (!rst_n) begin
            r_grant   <= '0;
            r_last    <= GW'(N_SRC - 1);
            r_cnt     <= '0;
            r_pkt_cnt <= '0;
            r_len_err <= 1'b0;
        end else begin
            r_len_err <= w_done & ~(w_src_eop & (r_cnt == LAST_BEAT));
            if (w_start) begin
                r_grant <= w_pick;
                r_cnt   <= '0;
            end
            if (w_xfer) r_cnt <= r_cnt + 1'b1;
            if (w_done) begin
                r_last    <= r_grant;
                r_pkt_cnt <= r_pkt_cnt + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_st_pkt_arbiter.sv
// tb_st_pkt_arbiter: scoreboard bench with a packet-level round-robin reference model
module tb_st_pkt_arbiter;
    localparam int N  = 4;
    localparam int ST = 8;
    localparam int PB = 128;
    localparam int GW = 2;

    logic            clk_st = 1'b0;
    logic            rst_n, cfg_en;
    logic [N*ST-1:0] src_data;
    logic [N-1:0]    src_valid, src_sop, src_eop, src_ready;
    logic [ST-1:0]   dst_data;
    logic            dst_valid, dst_sop, dst_eop, dst_ready;
    logic [GW-1:0]   grant_id;
    logic            busy, len_err;
    logic [15:0]     pkt_cnt;

    typedef struct { logic [ST-1:0] d; logic sop; logic eop; } beat_t;
    typedef struct { logic [ST-1:0] d; logic sop; logic eop; logic err; logic [GW-1:0] gid; } exp_t;

    beat_t         src_q[N][$];
    exp_t          exp_q[$];
    logic [ST-1:0] m_dat[N][$];
    int            m_len[N][$];
    bit            m_eopf[N][$];
    int            m_last = N - 1;
    int            m_cnt = 0;
    int            errors = 0;
    int            checks = 0;
    int            beats_seen = 0;
    bit            stall_en = 1'b0;
    int            rdy_mode = 0;

    st_pkt_arbiter #(.N_SRC(N), .ST(ST), .PKT_BEATS(PB)) dut (
        .clk_st(clk_st), .rst_n(rst_n), .cfg_en(cfg_en),
        .src_data(src_data), .src_valid(src_valid), .src_sop(src_sop), .src_eop(src_eop),
        .src_ready(src_ready),
        .dst_data(dst_data), .dst_valid(dst_valid), .dst_sop(dst_sop), .dst_eop(dst_eop),
        .dst_ready(dst_ready),
        .grant_id(grant_id), .busy(busy), .len_err(len_err), .pkt_cnt(pkt_cnt)
    );

    always #5 clk_st = ~clk_st;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int src_left();
        int n;
        n = 0;
        for (int s = 0; s < N; s++) n += src_q[s].size();
        return n;
    endfunction

    task automatic load_pkt(input int s, input int len, input bit eopf, input bit model);
        for (int j = 0; j < len; j++) begin
            beat_t b;
            b.d   = ST'($urandom);
            b.sop = (j == 0);
            b.eop = eopf && (j == len - 1);
            src_q[s].push_back(b);
            if (model) m_dat[s].push_back(b.d);
        end
        if (model) begin
            m_len[s].push_back(len);
            m_eopf[s].push_back(eopf);
        end
    endtask

    // Reference: serve pending packets round-robin, cut at PB beats, flag bad lengths
    task automatic model_run();
        forever begin
            int s, len, out;
            bit ef;
            exp_t e;
            logic [ST-1:0] d;
            s = -1;
            for (int k = 1; k <= N && s < 0; k++)
                if (m_len[(m_last + k) % N].size() > 0) s = (m_last + k) % N;
            if (s < 0) break;
            len = m_len[s].pop_front();
            ef  = m_eopf[s].pop_front();
            out = ef ? ((len < PB) ? len : PB) : PB;
            for (int j = 0; j < len; j++) begin
                d = m_dat[s].pop_front();
                if (j < out) begin
                    e.d = d; e.sop = (j == 0); e.eop = (j == out - 1);
                    e.err = !(ef && len == PB); e.gid = GW'(s);
                    exp_q.push_back(e);
                end
            end
            m_last = s;
            m_cnt++;
        end
    endtask

    task automatic wait_exp(input int budget);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < budget) begin @(negedge clk_st); #1; n++; end
        chk("exp_drain", exp_q.size(), 0);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() > 0 || src_left() > 0) && n < budget) begin @(negedge clk_st); #1; n++; end
        chk("drain", exp_q.size() + src_left(), 0);
        repeat (3) begin @(negedge clk_st); #1; end
    endtask

    task automatic wait_beats(input int target, input int budget);
        int n;
        n = 0;
        while (beats_seen < target && n < budget) begin @(negedge clk_st); #1; n++; end
        chk("beat_wait", beats_seen, target);
    endtask

    // Source and sink driver: retire accepted beats, present queue heads
    initial begin
        logic [N-1:0] hs;
        src_data = '0; src_valid = '0; src_sop = '0; src_eop = '0; dst_ready = 1'b1;
        forever begin
            @(negedge clk_st);
            hs = src_valid & src_ready;
            @(posedge clk_st);
            #1;
            for (int s = 0; s < N; s++) begin
                if (hs[s]) void'(src_q[s].pop_front());
                if (src_q[s].size() > 0) begin
                    src_data[s*ST +: ST] = src_q[s][0].d;
                    src_sop[s]   = src_q[s][0].sop;
                    src_eop[s]   = src_q[s][0].eop;
                    src_valid[s] = src_q[s][0].sop || !stall_en || ($urandom_range(3) != 0);
                end else begin
                    src_valid[s] = 1'b0; src_sop[s] = 1'b0; src_eop[s] = 1'b0;
                end
            end
            dst_ready = (rdy_mode == 0) || (rdy_mode == 1 && !dst_ready) ||
                        (rdy_mode == 2 && $urandom_range(3) != 0);
        end
    end

    // Monitor: compare every accepted beat and the post-EOP cycle against the scoreboard
    initial begin
        bit   err_pend, err_exp, gap_pend;
        exp_t e;
        err_pend = 0; err_exp = 0; gap_pend = 0;
        forever begin
            @(negedge clk_st);
            if (err_pend) begin
                chk("len_err", len_err, err_exp);
                chk("idle_after_eop", busy, 0);
                gap_pend = cfg_en && exp_q.size() > 0;
                err_pend = 0;
            end else begin
                if (gap_pend) begin
                    chk("first_beat_after_gap", {busy, dst_valid, dst_sop}, 3'b111);
                    gap_pend = 0;
                end
                if (len_err) chk("len_err_spurious", len_err, 0);
            end
            if (dst_valid && dst_ready) begin
                if (exp_q.size() == 0) chk("unexpected_beat", exp_q.size(), 1);
                else begin
                    e = exp_q.pop_front();
                    chk("data", dst_data, e.d);
                    chk("sop", dst_sop, e.sop);
                    chk("eop", dst_eop, e.eop);
                    chk("grant_id", grant_id, e.gid);
                    beats_seen++;
                    if (e.eop) begin err_pend = 1; err_exp = e.err; end
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        beat_t ob;
        int    base;
        rst_n = 1'b0;
        cfg_en = 1'b0;
        ob.d = 8'h5A; ob.sop = 1'b0; ob.eop = 1'b1;
        src_q[1].push_back(ob);
        repeat (2) @(negedge clk_st);
        #1;
        chk("rst_src_ready_flush", src_ready, 4'b0010);
        chk("rst_busy", busy, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_dst_valid", dst_valid, 0);
        chk("rst_dst_sop", dst_sop, 0);
        chk("rst_dst_eop", dst_eop, 0);
        chk("rst_len_err", len_err, 0);
        chk("rst_pkt_cnt", pkt_cnt, 0);
        rst_n = 1'b1;

        // all four sources requesting: order 0,1,2,3,0
        for (int s = 0; s < N; s++) load_pkt(s, PB, 1, 1);
        load_pkt(0, 5, 1, 1);
        model_run();
        stall_en = 1; rdy_mode = 2; cfg_en = 1;
        wait_idle(8000);
        chk("pkt_cnt_rr", pkt_cnt, m_cnt);

        // single source, full-length packet, sink always ready
        stall_en = 0; rdy_mode = 0;
        base = beats_seen;
        load_pkt(0, PB, 1, 1);
        model_run();
        wait_idle(2000);
        chk("single_beats", beats_seen - base, PB);
        chk("pkt_cnt_single", pkt_cnt, m_cnt);

        // short packet: EOP at beat 63
        stall_en = 1; rdy_mode = 2;
        load_pkt(1, 64, 1, 1);
        model_run();
        wait_idle(2000);
        chk("pkt_cnt_short", pkt_cnt, m_cnt);

        // long packet: 130 beats without EOP, two trailing beats drained in IDLE
        stall_en = 0; rdy_mode = 0;
        load_pkt(2, PB + 2, 0, 1);
        model_run();
        wait_exp(2000);
        for (int j = 0; j < 2; j++) begin
            @(negedge clk_st); #1;
            chk("long_flush_ready", src_ready, 4'b0100);
            chk("long_flush_dst_valid", dst_valid, 0);
        end
        @(negedge clk_st); #1;
        chk("long_flush_done", src_ready, 4'b0000);
        wait_idle(2000);
        chk("pkt_cnt_long", pkt_cnt, m_cnt);

        // toggling sink, cfg_en dropped mid-packet; second packet waits for cfg_en
        rdy_mode = 1;
        base = beats_seen;
        load_pkt(3, PB, 1, 1);
        load_pkt(0, 20, 1, 1);
        model_run();
        wait_beats(base + 10, 2000);
        cfg_en = 0;
        wait_beats(base + PB, 2000);
        repeat (6) begin
            @(negedge clk_st); #1;
            chk("no_grant_while_disabled", {busy, dst_valid}, 2'b00);
        end
        cfg_en = 1;
        wait_idle(2000);
        chk("pkt_cnt_cfg", pkt_cnt, m_cnt);

        // reset at beat 50: packet dropped, priority returns to source 0
        rdy_mode = 0; stall_en = 0;
        base = beats_seen;
        load_pkt(1, PB, 1, 0);
        for (int j = 0; j < 50; j++) begin
            exp_t e;
            e.d = src_q[1][j].d; e.sop = (j == 0); e.eop = 1'b0; e.err = 1'b0; e.gid = 2'd1;
            exp_q.push_back(e);
        end
        wait_beats(base + 50, 2000);
        rst_n = 1'b0;
        @(negedge clk_st); #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_pkt_cnt", pkt_cnt, 0);
        chk("midrst_len_err", len_err, 0);
        chk("midrst_grant_id", grant_id, 0);
        rst_n = 1'b1;
        m_last = N - 1;
        m_cnt = 0;
        load_pkt(2, 20, 1, 1);
        load_pkt(0, 20, 1, 1);
        model_run();
        stall_en = 1; rdy_mode = 2;
        wait_idle(4000);
        chk("pkt_cnt_after_rst", pkt_cnt, m_cnt);

        // randomized mix of full, truncated-at-128 and short packets
        for (int p = 0; p < 3; p++)
            for (int s = 0; s < N; s++) begin
                int r;
                r = $urandom_range(3);
                if (r == 0)      load_pkt(s, PB, 1, 1);
                else if (r == 1) load_pkt(s, PB, 0, 1);
                else             load_pkt(s, $urandom_range(PB - 1, 1), 1, 1);
            end
        model_run();
        wait_idle(20000);
        chk("pkt_cnt_random", pkt_cnt, m_cnt);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
